// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Covers the fetch FSM encoding, the IF/ID payload layout and the PC look-ahead.
package fetch_unit_pkg;

    localparam logic [1:0] FETCH_START = 2'd0;
    localparam logic [1:0] FETCH       = 2'd1;
    localparam logic [1:0] HOLD        = 2'd2;
    localparam logic [1:0] DISCARD     = 2'd3;

    localparam logic [31:0] PC_AHEAD = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus8;
    } ifid_t;

    function automatic ifid_t make_ifid(input logic [31:0] instr,
                                        input logic [31:0] pc);
        ifid_t r;
        r.instr   = instr;
        r.pc      = pc;
        r.pcplus8 = pc + PC_AHEAD;
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_target.sv
// Redirect target selection for the fetch stage.
// An R15 write beats a taken branch; both are purely combinational.
module branch_target_calc
    import fetch_unit_pkg::*;
(
    input  logic        PCWriteE_i,
    input  logic        BranchTakenE_i,
    input  logic [31:0] BranchPC_i,
    input  logic [31:0] ExtImm_i,
    input  logic [31:0] ALUResult_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    logic [31:0] branch_tgt;
    logic [31:0] alu_tgt;

    assign branch_tgt = BranchPC_i + PC_AHEAD + ExtImm_i;
    assign alu_tgt    = ALUResult_i & 32'hFFFF_FFFC;

    always_comb begin
        redirect_o = PCWriteE_i | BranchTakenE_i;
        target_o   = branch_tgt;
        if (PCWriteE_i) begin
            target_o = alu_tgt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the memory handshake and IF/ID.
// A one-entry hold buffer parks a returned word while decode is stalled.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        StallD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchPC,
    input  logic [31:0] ExtImm,
    input  logic        PCWriteE,
    input  logic [31:0] ALUResult,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    ifid_t       ifid_q, ifid_d;
    ifid_t       hold_q, hold_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] target;
    logic        req;
    logic        in_discard;

    branch_target_calc u_tgt (
        .PCWriteE_i     (PCWriteE),
        .BranchTakenE_i (BranchTakenE),
        .BranchPC_i     (BranchPC),
        .ExtImm_i       (ExtImm),
        .ALUResult_i    (ALUResult),
        .redirect_o     (redirect),
        .target_o       (target)
    );

    assign in_discard = (state_q == DISCARD);
    assign req        = (state_q == FETCH) || in_discard;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        // The abandoned request keeps its address until memory answers.
        addr_d  = in_discard ? addr_q : pc_q;

        if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
            hold_d  = '0;
            state_d = (req && !IMemReady) ? DISCARD : FETCH;
        end else begin
            unique case (state_q)
                FETCH_START: state_d = FETCH;
                FETCH: begin
                    if (IMemReady) begin
                        pc_d = pc_q + PC_INC;
                        if (StallD) begin
                            hold_d  = make_ifid(IMemRData, pc_q);
                            state_d = HOLD;
                        end else begin
                            ifid_d  = make_ifid(IMemRData, pc_q);
                            valid_d = 1'b1;
                        end
                    end else if (!StallD) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!StallD) begin
                        ifid_d  = hold_q;
                        valid_d = 1'b1;
                        hold_d  = '0;
                        state_d = FETCH;
                    end
                end
                DISCARD: begin
                    if (IMemReady) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH_START;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= FETCH_START;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ifid_q  <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ifid_q  <= ifid_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign IMemReq  = req;
    assign IMemAddr = in_discard ? addr_q : pc_q;
    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus8D = ifid_q.pcplus8;
    assign ValidD   = valid_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the ARM core; owns the PC and the IF/ID pipeline register.
- Issues requests to a variable-latency instruction memory using a req/ready handshake, and presents fetched instructions to decode with a valid bit.
- Consumes ExtImm from the immediate-extension stage. Branch target = BranchPC + 8 + ExtImm.
- Also accepts ALU writes to R15. A 1-entry hold buffer absorbs decode stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, sequential PC increment in bytes

Ports:
CLK  input  1  clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
StallD  input  1  decode cannot accept an instruction this cycle
BranchTakenE  input  1  redirect to the branch target this cycle
BranchPC  input  32  PC of the branch instruction
ExtImm  input  32  extended branch offset, already shifted by 2
PCWriteE  input  1  redirect to ALUResult (R15 write)
ALUResult  input  32  R15 write value
IMemReq  output  1  instruction request valid
IMemAddr  output  32  fetch address
IMemReady  input  1  data valid / request complete
IMemRData  input  32  instruction word, valid when IMemReady=1
InstrD  output  32  instruction to decode
PCD  output  32  address of InstrD
PCPlus8D  output  32  PCD + 8
ValidD  output  1  InstrD is valid

Behaviour:
- Reset (sampled at the edge) sets:
  - PC = RESET_PC
  - state = FETCH_START
  - IMemReq = 0, IMemAddr = RESET_PC
  - ValidD = 0, InstrD = 0, PCD = 0, PCPlus8D = 0
  - hold buffer empty
- Reset overrides every other input. A Reset asserted mid-request abandons the request; a late IMemReady is ignored because IMemReq is 0.
- States:
  - FETCH_START: IMemReq = 0. Next cycle → FETCH.
  - FETCH: IMemReq = 1, IMemAddr = PC.
    - Address is held stable until IMemReady.
    - On IMemReady with no redirect and StallD = 0: IF/ID loads {IMemRData, PC, PC+8}, ValidD = 1, PC += PC_INC. Stay in FETCH, so the next request is issued back-to-back.
    - On IMemReady with StallD = 1: word goes to the hold buffer, PC += PC_INC → HOLD.
    - No IMemReady: ValidD is cleared if StallD = 0, otherwise held.
  - HOLD: IMemReq = 0. IF/ID is unchanged while StallD = 1. When StallD = 0, the hold buffer moves to IF/ID (ValidD = 1) → FETCH.
  - DISCARD: entered on a redirect while a request is outstanding without IMemReady.
    - IMemReq stays 1 and IMemAddr stays at the old address (the handshake is never retracted).
    - PC already holds the target.
    - On IMemReady the data is dropped → FETCH.
    - A further redirect in DISCARD overwrites PC only.
- Redirect priority: Reset > PCWriteE > BranchTakenE > StallD > normal.
  - PCWriteE target = {ALUResult[31:2], 2'b00}.
  - Branch target = BranchPC + 32'd8 + ExtImm, modulo 2^32 (wraps silently).
- Redirect effects (any state), on the next edge:
  - PC = target, ValidD = 0, hold buffer cleared.
  - A word returned in the same cycle as the redirect is dropped.
  - Next state: FETCH if no request is outstanding or IMemReady = 1 this cycle; otherwise DISCARD.
- Redirect overrides StallD: the flush happens even when decode is stalled.
- PC increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Fetch latency is 1 cycle per instruction with a zero-wait memory (IMemReady tied high after the request).

Decomposition:
- Shared package:
  - fetch state enum {FETCH_START, FETCH, HOLD, DISCARD}
  - constant PC_AHEAD = 8
  - IF/ID payload struct {instr, pc, pcplus8}
- One natural sub-module, branch_target_calc: combinational target selection. It computes BranchPC + 8 + ExtImm, aligns ALUResult, and applies the priority mux. This keeps fetch_unit as PC, FSM, and registers only.

Test Plan:
- Reset, then IMemReady tied 1 with IMemRData = addr ^ 32'hA5A5A5A5 → IMemAddr sequence 0, 4, 8, 12 on consecutive cycles; InstrD/PCD follow one cycle later with ValidD = 1.
- BranchTakenE = 1, BranchPC = 32'h100, ExtImm = 32'hFFFF_FFF8 (-8) → next IMemAddr = 32'h100; ValidD = 0 for one cycle; the in-flight word is dropped.
- Redirect while a request is outstanding with IMemReady delayed 3 cycles → IMemAddr held at the old address, state DISCARD. Returned data is never presented. The next request uses the target.
- StallD = 1 for 4 cycles while a word returns → IMemReq = 0 during stall, InstrD unchanged. On release the held word appears with the correct PCD. No instruction is lost or duplicated.
- PCWriteE = 1 and BranchTakenE = 1 in the same cycle, ALUResult = 32'h203 → IMemAddr = 32'h200 (PCWriteE wins, aligned).
- PC = 32'hFFFF_FFFC sequential fetch → next IMemAddr = 0. Reset asserted mid-DISCARD → IMemReq = 0, ValidD = 0, PC = RESET_PC next cycle.
